anc_sequencer: RTL

ANC_SEQUENCER -- requirements
Module: anc_sequencer

---
 rtl/anc_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/anc_sequencer.sv
// ANC frame sequencer: runs lowpass, NLMS and FIR stages one at a time
// per audio sample, with a per-stage watchdog, sticky flags and counters.
module anc_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sample_ready_in,
  input  logic             nc_on_in,
  input  logic             adapt_en_in,
  input  logic             clear_flags_in,
  output logic             lp_start_out,
  output logic             lms_start_out,
  output logic             fir_start_out,
  input  logic             lp_done_in,
  input  logic             lms_done_in,
  input  logic             fir_done_in,
  output logic             y_valid_out,
  output logic             bypass_out,
  output logic             busy_out,
  output logic [2:0]       state_out,
  output logic             overrun_out,
  output logic             timeout_out,
  output logic [CNT_W-1:0] frame_count_out,
  output logic [CNT_W-1:0] drop_count_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LP   = 3'd1,
    S_LMS  = 3'd2,
    S_FIR  = 3'd3
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             lp_start_q, lp_start_d;
  logic             lms_start_q, lms_start_d;
  logic             fir_start_q, fir_start_d;
  logic             y_valid_q, y_valid_d;
  logic             bypass_q, bypass_d;
  logic             nc_q, nc_d;
  logic             adapt_q, adapt_d;
  logic             ovr_q, ovr_d;
  logic             to_q, to_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic stage_done;
  logic done_ok;
  logic wd_exp;
  logic set_ovr;
  logic set_to;

  // Select the done pulse of the running stage; others are ignored
  always_comb begin
    stage_done = 1'b0;
    unique case (1'b1)
      (state_q == S_LP):  stage_done = lp_done_in;
      (state_q == S_LMS): stage_done = lms_done_in;
      (state_q == S_FIR): stage_done = fir_done_in;
      default:            stage_done = 1'b0;
    endcase
  end

  // Next-state, pulse, watchdog, flag and counter logic
  always_comb begin
    state_d     = state_q;
    lp_start_d  = 1'b0;
    lms_start_d = 1'b0;
    fir_start_d = 1'b0;
    y_valid_d   = 1'b0;
    bypass_d    = bypass_q;
    nc_d        = nc_q;
    adapt_d     = adapt_q;
    wd_d        = wd_q + WD_W'(1);
    drop_d      = drop_q;
    set_ovr     = 1'b0;
    set_to      = 1'b0;
    // done in a start-pulse cycle is not accepted
    done_ok     = stage_done &
                  ~(lp_start_q | lms_start_q | fir_start_q);
    wd_exp      = (wd_q == WD_LAST);

    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (sample_ready_in) begin
          state_d    = S_LP;
          lp_start_d = 1'b1;
          nc_d       = nc_on_in;
          adapt_d    = adapt_en_in;
          bypass_d   = 1'b0;
        end
      end
      S_LP: begin
        if (done_ok) begin
          wd_d = '0;
          if (!nc_q) begin
            state_d   = S_IDLE;
            y_valid_d = 1'b1;
            bypass_d  = 1'b1;
          end else if (adapt_q) begin
            state_d     = S_LMS;
            lms_start_d = 1'b1;
          end else begin
            state_d     = S_FIR;
            fir_start_d = 1'b1;
          end
        end else if (wd_exp) begin
          state_d = S_IDLE;
          set_to  = 1'b1;
        end
      end
      S_LMS: begin
        if (done_ok) begin
          wd_d        = '0;
          state_d     = S_FIR;
          fir_start_d = 1'b1;
        end else if (wd_exp) begin
          state_d = S_IDLE;
          set_to  = 1'b1;
        end
      end
      S_FIR: begin
        if (done_ok) begin
          wd_d      = '0;
          state_d   = S_IDLE;
          y_valid_d = 1'b1;
          bypass_d  = 1'b0;
        end else if (wd_exp) begin
          state_d = S_IDLE;
          set_to  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        wd_d    = '0;
      end
    endcase

    if (state_q != S_IDLE && sample_ready_in) begin
      set_ovr = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end

    fc_d  = fc_q + CNT_W'(y_valid_d);
    // a set event in the same cycle as clear keeps the flag high
    ovr_d = (ovr_q & ~clear_flags_in) | set_ovr;
    to_d  = (to_q & ~clear_flags_in) | set_to;
  end

  // Single register bank for FSM state and all registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      lp_start_q  <= 1'b0;
      lms_start_q <= 1'b0;
      fir_start_q <= 1'b0;
      y_valid_q   <= 1'b0;
      bypass_q    <= 1'b0;
      nc_q        <= 1'b0;
      adapt_q     <= 1'b0;
      ovr_q       <= 1'b0;
      to_q        <= 1'b0;
      wd_q        <= '0;
      fc_q        <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      lp_start_q  <= lp_start_d;
      lms_start_q <= lms_start_d;
      fir_start_q <= fir_start_d;
      y_valid_q   <= y_valid_d;
      bypass_q    <= bypass_d;
      nc_q        <= nc_d;
      adapt_q     <= adapt_d;
      ovr_q       <= ovr_d;
      to_q        <= to_d;
      wd_q        <= wd_d;
      fc_q        <= fc_d;
      drop_q      <= drop_d;
    end
  end

  assign lp_start_out    = lp_start_q;
  assign lms_start_out   = lms_start_q;
  assign fir_start_out   = fir_start_q;
  assign y_valid_out     = y_valid_q;
  assign bypass_out      = bypass_q;
  assign busy_out        = (state_q != S_IDLE);
  assign state_out       = state_q;
  assign overrun_out     = ovr_q;
  assign timeout_out     = to_q;
  assign frame_count_out = fc_q;
  assign drop_count_out  = drop_q;

endmodule
